// File: rtl/shift_pkg.sv
// Shared types and constants for the 16-bit serial deserializer.
package shift_pkg;

  localparam int SHIFT_W = 16;

  typedef enum logic {ST_IDLE, ST_SHIFT} deser_state_e;

  typedef logic [SHIFT_W-1:0] shift_word_t;

  localparam logic ORD_MSB_FIRST = 1'b0;
  localparam logic ORD_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deser_outreg.sv
// Valid/ready holding register for completed words, with sticky overrun detection.
// Optional SHIFT_DESER_PARITY_EN adds a parity error flag that travels with the word.
module shift_deser_outreg
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_complete,
  input  logic [WIDTH-1:0] i_word,
`ifdef SHIFT_DESER_PARITY_EN
  input  logic             i_perr,
  output logic             o_perr,
`endif
  input  logic             i_ready,
  input  logic             i_overrun_clr,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overrun;
  logic             w_accept;
  logic             w_drop;
  logic             w_consume;

  // A held word may be replaced only in the same cycle it is being consumed.
  assign w_accept  = i_complete && (!r_valid || i_ready);
  assign w_drop    = i_complete && r_valid && !i_ready;
  assign w_consume = !i_complete && r_valid && i_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_word  <= i_word;
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef SHIFT_DESER_PARITY_EN
  logic r_perr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perr <= 1'b0;
    end else if (w_accept) begin
      r_perr <= i_perr;
    end else if (w_consume) begin
      r_perr <= 1'b0;
    end
  end

  assign o_perr = r_perr;
`endif

  assign o_word    = r_word;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/shift_deser16.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit words MSB- or LSB-first.
// Define SHIFT_DESER_PARITY_EN for a trailing even-parity bit and the parity_err output.
module shift_deser16
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_W,
`ifdef SHIFT_DESER_PARITY_EN
  parameter int CNT_W = $clog2(WIDTH + 1)
`else
  parameter int CNT_W = $clog2(WIDTH)
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  input  logic             overrun_clr,
`ifdef SHIFT_DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

`ifdef SHIFT_DESER_PARITY_EN
  localparam int LAST_CNT = WIDTH;
`else
  localparam int LAST_CNT = WIDTH - 1;
`endif

  deser_state_e     r_state;
  deser_state_e     w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_shifted;
  logic [WIDTH-1:0] w_word;
  logic             r_ord;
  logic             w_ord;
  logic             w_last;
  logic             w_complete;
  logic             w_shift_en;

  // The order input is only honoured on the first bit of a word.
  assign w_ord        = (r_state == ST_IDLE) ? lsb_first : r_ord;
  assign w_sr_shifted = (w_ord == ORD_LSB_FIRST) ? {ser_in, r_sr[WIDTH-1:1]}
                                                 : {r_sr[WIDTH-2:0], ser_in};
  assign w_last       = (r_state == ST_SHIFT) && (r_count == CNT_W'(LAST_CNT));
  assign w_complete   = ser_valid && w_last;

`ifdef SHIFT_DESER_PARITY_EN
  logic w_perr;

  // The parity bit is checked against the assembled data but never shifted in.
  assign w_shift_en = ser_valid && !w_last;
  assign w_word     = r_sr;
  assign w_perr     = ser_in ^ (^r_sr);
`else
  assign w_shift_en = ser_valid;
  assign w_word     = w_sr_shifted;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (ser_valid) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_complete) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_sr    <= '0;
      r_ord   <= ORD_MSB_FIRST;
    end else if (ser_valid) begin
      if (r_state == ST_IDLE) begin
        r_ord <= lsb_first;
      end
      if (w_shift_en) begin
        r_sr <= w_sr_shifted;
      end
      r_count <= w_complete ? '0 : r_count + CNT_W'(1);
    end
  end

  assign busy = (r_state == ST_SHIFT);

  shift_deser_outreg #(
    .WIDTH(WIDTH)
  ) u_outreg (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_complete   (w_complete),
    .i_word       (w_word),
`ifdef SHIFT_DESER_PARITY_EN
    .i_perr       (w_perr),
    .o_perr       (parity_err),
`endif
    .i_ready      (word_ready),
    .i_overrun_clr(overrun_clr),
    .o_word       (word_out),
    .o_valid      (word_valid),
    .o_overrun    (overrun)
  );

endmodule

// File: tb/tb_shift_deser16.sv
// Randomized and directed bench for shift_deser16 against a frame-level reference model.
module tb_shift_deser16;

  localparam int W = 16;
`ifdef SHIFT_DESER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         lsb_first = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready = 1'b1;
  logic         overrun;
  logic         overrun_clr = 1'b0;
  logic         busy;
`ifdef SHIFT_DESER_PARITY_EN
  logic         parity_err;
`endif

  shift_deser16 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .lsb_first  (lsb_first),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
`ifdef SHIFT_DESER_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the current frame, plus the output holding register.
  bit           m_q[$];
  logic         m_ord;
  logic [W-1:0] m_word;
  logic         m_valid;
  logic         m_overrun;
  logic         m_perr;
  bit           chk_en = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_ord     = 1'b0;
    m_word    = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_perr    = 1'b0;
  endfunction

  function automatic void model_step(input logic sv, input logic b, input logic lsb,
                                     input logic rdy, input logic clr);
    logic         done = 1'b0;
    logic         pe = 1'b0;
    logic         drop = 1'b0;
    logic [W-1:0] w = '0;
    if (sv) begin
      if (m_q.size() == 0) m_ord = lsb;
      m_q.push_back(b);
      if (m_q.size() == FRAME) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          if (m_ord) w[i] = m_q[i];
          else       w[W-1-i] = m_q[i];
        end
`ifdef SHIFT_DESER_PARITY_EN
        pe = (m_q[W] != (^w));
`endif
        m_q.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_word  = w;
        m_valid = 1'b1;
        m_perr  = pe;
      end else begin
        drop = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
      m_perr  = 1'b0;
    end
    if (clr)  m_overrun = 1'b0;
    if (drop) m_overrun = 1'b1;
  endfunction

  // One clock: present inputs, let the model see them at the edge, return 1 time unit later.
  task automatic cycle(input logic sv, input logic b, input logic lsb);
    ser_valid = sv;
    ser_in    = b;
    lsb_first = lsb;
    @(posedge clk);
    if (reset_n) model_step(sv, b, lsb, word_ready, overrun_clr);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic lsb, input logic toggle,
                           input logic [31:0] gap_after, input logic bad_par,
                           input logic rdy_on_last);
    for (int i = 0; i < FRAME; i++) begin
      logic b;
      if (i < W) b = lsb ? w[i] : w[W-1-i];
      else       b = (^w) ^ bad_par;
      if (rdy_on_last && i == FRAME - 1) word_ready = 1'b1;
      cycle(1'b1, b, toggle ? (lsb ^ 1'(i)) : lsb);
      if (gap_after[i]) begin
        for (int g = 0; g < 3; g++) begin
          cycle(1'b0, 1'($urandom), 1'($urandom));
          check("gap_busy", busy, 1);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("word_valid", word_valid, m_valid);
      check("word_out", word_out, m_word);
      check("overrun", overrun, m_overrun);
      check("busy", busy, m_q.size() != 0);
`ifdef SHIFT_DESER_PARITY_EN
      check("parity_err", parity_err, m_perr);
`endif
    end
  end

  initial begin
    model_reset();
    chk_en = 1;
    idle(2);
    reset_n = 1'b1;
    check("reset_word", word_out, 0);
    check("reset_valid", word_valid, 0);
    idle(2);

    word_ready = 1'b1;
    send_word(16'hA5C3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("msb_valid", word_valid, 1);
    check("msb_word", word_out, 16'hA5C3);
    check("msb_overrun", overrun, 0);
    idle(1);
    check("msb_pulse_end", word_valid, 0);

    send_word(16'h1234, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    check("lsb_word", word_out, 16'h1234);
    idle(2);

    send_word(16'h8001, 1'b0, 1'b0, 32'h4081, 1'b0, 1'b0);
    check("gap_word", word_out, 16'h8001);
    idle(2);

    word_ready = 1'b0;
    send_word(16'h00FF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("bp_first", word_out, 16'h00FF);
    send_word(16'hFF00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("bp_hold", word_out, 16'h00FF);
    check("bp_overrun", overrun, 1);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    check("bp_clr", overrun, 0);
    word_ready = 1'b1;
    idle(2);

    word_ready = 1'b0;
    send_word(16'hDEAD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("b2b_first", word_out, 16'hDEAD);
    send_word(16'hBEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("b2b_valid", word_valid, 1);
    check("b2b_second", word_out, 16'hBEEF);
    check("b2b_overrun", overrun, 0);
    idle(2);

    for (int i = 0; i < 7; i++) cycle(1'b1, 1'($urandom), 1'b0);
    reset_n = 1'b0;
    model_reset();
    cycle(1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_valid", word_valid, 0);
    send_word(16'h5555, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_word", word_out, 16'h5555);
`ifdef SHIFT_DESER_PARITY_EN
    check("par_ok", parity_err, 0);
    send_word(16'h5555, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("par_bad", parity_err, 1);
    check("par_bad_valid", word_valid, 1);
`endif
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      word_ready  = ($urandom_range(0, 2) != 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
    end
    overrun_clr = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_deser16.md
Name: shift_deser16

Overview:
- Serial-to-parallel receiver: the receiving end of the 16-bit shift-out path.
- Collects bits presented one per accepted cycle and rebuilds the 16-bit word in a shift register.
- Presents each completed word to downstream logic through a valid/ready holding register.
- Supports MSB-first and LSB-first streams; the order is latched per word.

Parameters:
- WIDTH, 16, word length in bits (minimum 2).
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is valid this cycle; always accepted.
- lsb_first  input  1  bit order: 1 = LSB first, 0 = MSB first; sampled on the first bit of each word.
- word_out  output  WIDTH  completed word; stable while word_valid=1.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  downstream consumes word_out when word_valid && word_ready.
- overrun  output  1  sticky: a completed word was dropped.
- overrun_clr  input  1  synchronous clear of overrun.
- busy  output  1  a partial word is in progress (state SHIFT).

Behaviour:
- Clock, reset and interface: single clock clk; reset_n is asynchronous, active-low.
- Reset values: state=IDLE, count=0, shift register=0, word_out=0, word_valid=0, overrun=0, busy=0, latched order=0.
- Reset asserted mid-word discards the partial word and any held word.

FSM (2 states):
- IDLE:
  - ser_valid=1 latches lsb_first into ord_q.
  - Shifts the first bit in; count becomes 1; next state SHIFT.
  - ser_valid=0: stay in IDLE.
- SHIFT:
  - Each ser_valid cycle shifts one bit and increments count.
  - On the bit taken with count==WIDTH-1, the word completes; count returns to 0; next state IDLE.
  - Cycles with ser_valid=0 are gaps: hold state and count, no timeout.
- Changes on lsb_first while in SHIFT are ignored.

Shift rules:
- ord_q=0 (MSB first): sr <= {sr[WIDTH-2:0], ser_in}.
- ord_q=1 (LSB first): sr <= {ser_in, sr[WIDTH-1:1]}.
- For a completing bit, the shift is applied combinationally before capture, so the final bit is included in the captured word.

Output register:
- Latency: word_out and word_valid update on the clock edge that accepts the last bit; visible the next cycle.
- Completion, word_valid=0: capture the word; word_valid <= 1.
- Completion, word_valid=1, word_ready=1 in the same cycle: capture the new word; word_valid stays 1 (back-to-back, no bubble).
- Completion, word_valid=1, word_ready=0: the new word is dropped; word_out is unchanged; overrun <= 1.
- No completion, word_valid && word_ready: word_valid <= 0; word_out holds its last value.

Overrun:
- Cleared only by reset or by overrun_clr.
- overrun_clr and a new overrun event in the same cycle: overrun = 1 (set wins).

Other:
- busy = (state==SHIFT).
- The minimum inter-word spacing is WIDTH accepted bits; the receiver sustains one bit per cycle continuously.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- When defined:
  - Each frame is WIDTH+1 bits; the extra bit follows the data and carries even parity over the WIDTH data bits.
  - Adds output parity_err (1 bit), set together with word_valid when the parity bit mismatches and cleared when word_valid clears.
  - The word is delivered regardless of parity_err.
  - Counter range becomes 0..WIDTH, and the parity bit is not shifted into sr.
- When undefined: frame is WIDTH bits; no parity_err port.

Decomposition:
- Package shift_pkg:
  - SHIFT_W = 16.
  - typedef enum {ST_IDLE, ST_SHIFT} deser_state_e.
  - typedef logic [SHIFT_W-1:0] shift_word_t.
  - localparams ORD_MSB_FIRST = 1'b0, ORD_LSB_FIRST = 1'b1.
- One sub-module is natural: shift_deser_outreg, the valid/ready holding register with overrun detection; the shift register, counter and FSM stay in the top.

Test Plan:
- MSB-first word: lsb_first=0, 16 contiguous bits of 16'hA5C3 MSB first, word_ready=1 -> word_valid pulses 1 cycle after bit 16, word_out=16'hA5C3, overrun=0.
- LSB-first word: lsb_first=1, bits of 16'h1234 LSB first; toggle lsb_first mid-word -> word_out=16'h1234.
- Gaps: 16'h8001 sent with ser_valid low for 3 cycles after bits 1, 8 and 15 -> busy=1 throughout the gaps, word_out=16'h8001.
- Backpressure: word_ready=0; send 16'h00FF then 16'hFF00 -> word_out stays 16'h00FF, overrun=1; overrun_clr pulse -> overrun=0.
- Back-to-back: word_ready=1 on the completing cycle; two words 16'hDEAD, 16'hBEEF sent continuously -> word_valid stays high across the boundary, word_out=16'hDEAD then 16'hBEEF.
- Reset mid-word: reset_n low after 7 bits, then send 16'h5555 -> no word from the partial; word_out=16'h5555 only; with SHIFT_DESER_PARITY_EN, a wrong parity bit -> parity_err=1 with word_valid.
